// File: rtl/div_sqrt_share_arb_mvp.sv
// Purpose: round-robin arbiter sharing one div/sqrt unit among NUM_REQ requesters.
// Latency: grant at t, start pulse at t+1, response the cycle after Unit_done_SI.
// Backpressure: holds the response until the owner's Rsp_ready_SI; no new grant until IDLE.

package defs_div_sqrt_mvp;
  localparam int C_PC        = 6;
  localparam int C_MANT_FP64 = 52;
  localparam int C_EXP_FP64  = 11;
endpackage

module div_sqrt_share_arb_mvp
  import defs_div_sqrt_mvp::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                                 Clk_CI,
  input  logic                                 Rst_RBI,
  input  logic [NUM_REQ-1:0]                   Req_valid_SI,
  output logic [NUM_REQ-1:0]                   Req_ready_SO,
  input  logic [NUM_REQ-1:0]                   Req_sqrt_SI,
  input  logic [NUM_REQ-1:0][C_MANT_FP64:0]    Req_mant_a_DI,
  input  logic [NUM_REQ-1:0][C_MANT_FP64:0]    Req_mant_b_DI,
  input  logic [NUM_REQ-1:0][C_EXP_FP64:0]     Req_exp_a_DI,
  input  logic [NUM_REQ-1:0][C_EXP_FP64:0]     Req_exp_b_DI,
  input  logic [NUM_REQ-1:0][1:0]              Req_fmt_SI,
  input  logic [NUM_REQ-1:0][C_PC-1:0]         Req_prec_SI,
  input  logic [NUM_REQ-1:0]                   Kill_SI,
  input  logic                                 Unit_ready_SI,
  input  logic                                 Unit_done_SI,
  input  logic [C_MANT_FP64+4:0]               Unit_mant_z_DI,
  input  logic [C_EXP_FP64+1:0]                Unit_exp_z_DI,
  output logic                                 Unit_div_start_SO,
  output logic                                 Unit_sqrt_start_SO,
  output logic                                 Unit_start_SO,
  output logic                                 Unit_kill_SO,
  output logic [C_MANT_FP64:0]                 Unit_mant_a_DO,
  output logic [C_MANT_FP64:0]                 Unit_mant_b_DO,
  output logic [C_EXP_FP64:0]                  Unit_exp_a_DO,
  output logic [C_EXP_FP64:0]                  Unit_exp_b_DO,
  output logic [1:0]                           Unit_fmt_SO,
  output logic [C_PC-1:0]                      Unit_prec_SO,
  output logic [NUM_REQ-1:0]                   Rsp_valid_SO,
  input  logic [NUM_REQ-1:0]                   Rsp_ready_SI,
  output logic [C_MANT_FP64+4:0]               Rsp_mant_z_DO,
  output logic [C_EXP_FP64+1:0]                Rsp_exp_z_DO,
  output logic                                 Busy_SO
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] owner_q;
  logic             sqrt_q;

  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] next_rr;
  logic             gnt_vld;
  logic             idle_gnt;
  logic             kill_own;
  int               cand;

  // Round-robin search: first valid requester at or after rr_q, wrapping.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!gnt_vld && Req_valid_SI[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  // Reset gating keeps the grant silent while reset is asserted.
  assign idle_gnt = Rst_RBI && (state_q == IDLE) && Unit_ready_SI && gnt_vld;
  assign kill_own = Kill_SI[owner_q];
  assign next_rr  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Grant strobe is one-hot only in the IDLE grant cycle.
  always_comb begin
    Req_ready_SO = '0;
    if (idle_gnt) Req_ready_SO[gnt_idx] = 1'b1;
  end

  // Response is shown to the owner only; a same-cycle kill withdraws it.
  always_comb begin
    Rsp_valid_SO = '0;
    if (state_q == RESP && !kill_own) Rsp_valid_SO[owner_q] = 1'b1;
  end

  // Start pulses are decoded from state so a kill in ISSUE can suppress them.
  assign Unit_div_start_SO  = (state_q == ISSUE) && !kill_own && !sqrt_q;
  assign Unit_sqrt_start_SO = (state_q == ISSUE) && !kill_own &&  sqrt_q;
  assign Unit_start_SO      = Unit_div_start_SO | Unit_sqrt_start_SO;
  assign Unit_kill_SO       = ((state_q == ISSUE) || (state_q == BUSY)) && kill_own;
  assign Busy_SO            = (state_q != IDLE);

  // Main FSM with operand, owner and result capture.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q        <= IDLE;
      rr_q           <= '0;
      owner_q        <= '0;
      sqrt_q         <= 1'b0;
      Unit_mant_a_DO <= '0;
      Unit_mant_b_DO <= '0;
      Unit_exp_a_DO  <= '0;
      Unit_exp_b_DO  <= '0;
      Unit_fmt_SO    <= '0;
      Unit_prec_SO   <= '0;
      Rsp_mant_z_DO  <= '0;
      Rsp_exp_z_DO   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_gnt) begin
            owner_q        <= gnt_idx;
            sqrt_q         <= Req_sqrt_SI[gnt_idx];
            Unit_mant_a_DO <= Req_mant_a_DI[gnt_idx];
            Unit_mant_b_DO <= Req_mant_b_DI[gnt_idx];
            Unit_exp_a_DO  <= Req_exp_a_DI[gnt_idx];
            Unit_exp_b_DO  <= Req_exp_b_DI[gnt_idx];
            Unit_fmt_SO    <= Req_fmt_SI[gnt_idx];
            Unit_prec_SO   <= Req_prec_SI[gnt_idx];
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (kill_own) begin
            rr_q    <= next_rr;
            state_q <= IDLE;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Kill takes priority over a coincident done.
          if (kill_own) begin
            rr_q    <= next_rr;
            state_q <= IDLE;
          end else if (Unit_done_SI) begin
            Rsp_mant_z_DO <= Unit_mant_z_DI;
            Rsp_exp_z_DO  <= Unit_exp_z_DI;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (kill_own || Rsp_ready_SI[owner_q]) begin
            rr_q    <= next_rr;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sqrt_share_arb_mvp.sv
// Purpose: directed self-checking bench for the shared div/sqrt arbiter.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: exercises held responses, unit-not-ready stalls, kills and reset.

module tb_div_sqrt_share_arb_mvp;
  import defs_div_sqrt_mvp::*;

  localparam int NUM_REQ = 2;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic [NUM_REQ-1:0]                req_valid, req_ready, req_sqrt, kill;
  logic [NUM_REQ-1:0]                rsp_valid, rsp_ready;
  logic [NUM_REQ-1:0][C_MANT_FP64:0] mant_a, mant_b;
  logic [NUM_REQ-1:0][C_EXP_FP64:0]  exp_a, exp_b;
  logic [NUM_REQ-1:0][1:0]           fmt;
  logic [NUM_REQ-1:0][C_PC-1:0]      prec;
  logic                              unit_ready, unit_done;
  logic [C_MANT_FP64+4:0]            unit_mant_z, rsp_mant_z;
  logic [C_EXP_FP64+1:0]             unit_exp_z, rsp_exp_z;
  logic                              div_start, sqrt_start, unit_start, unit_kill, busy;
  logic [C_MANT_FP64:0]              u_mant_a, u_mant_b;
  logic [C_EXP_FP64:0]               u_exp_a, u_exp_b;
  logic [1:0]                        u_fmt;
  logic [C_PC-1:0]                   u_prec;

  int vectors     = 0;
  int miscompares = 0;

  logic [C_MANT_FP64+4:0] z_held;

  always #5 clk = ~clk;

  div_sqrt_share_arb_mvp #(.NUM_REQ(NUM_REQ)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .Req_valid_SI(req_valid), .Req_ready_SO(req_ready), .Req_sqrt_SI(req_sqrt),
    .Req_mant_a_DI(mant_a), .Req_mant_b_DI(mant_b),
    .Req_exp_a_DI(exp_a), .Req_exp_b_DI(exp_b),
    .Req_fmt_SI(fmt), .Req_prec_SI(prec), .Kill_SI(kill),
    .Unit_ready_SI(unit_ready), .Unit_done_SI(unit_done),
    .Unit_mant_z_DI(unit_mant_z), .Unit_exp_z_DI(unit_exp_z),
    .Unit_div_start_SO(div_start), .Unit_sqrt_start_SO(sqrt_start),
    .Unit_start_SO(unit_start), .Unit_kill_SO(unit_kill),
    .Unit_mant_a_DO(u_mant_a), .Unit_mant_b_DO(u_mant_b),
    .Unit_exp_a_DO(u_exp_a), .Unit_exp_b_DO(u_exp_b),
    .Unit_fmt_SO(u_fmt), .Unit_prec_SO(u_prec),
    .Rsp_valid_SO(rsp_valid), .Rsp_ready_SI(rsp_ready),
    .Rsp_mant_z_DO(rsp_mant_z), .Rsp_exp_z_DO(rsp_exp_z),
    .Busy_SO(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with minimum unit latency; caller leaves the FSM in IDLE.
  task automatic run_op(input int g, input logic [C_MANT_FP64+4:0] z);
    #1;
    chk("rr_grant", 64'(req_ready), 64'(1) << g);
    tick();
    #1;
    chk("rr_div_start", 64'(div_start), 64'd1);
    chk("rr_opa", 64'(u_mant_a), 64'(mant_a[g]));
    tick();
    unit_done   = 1'b1;
    unit_mant_z = z;
    tick();
    unit_done = 1'b0;
    #1;
    chk("rr_rsp_valid", 64'(rsp_valid), 64'(1) << g);
    chk("rr_rsp_z", 64'(rsp_mant_z), 64'(z));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b01; req_sqrt = '0; kill = '0; rsp_ready = '0;
    mant_a = '0; mant_b = '0; exp_a = '0; exp_b = '0; fmt = '0; prec = '0;
    unit_ready = 1'b1; unit_done = 1'b0; unit_mant_z = '0; unit_exp_z = '0;

    // Reset state, with a request pending that must not be granted.
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_start", 64'(unit_start), 64'd0);
    chk("rst_opa", 64'(u_mant_a), 64'd0);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b1;

    // Both requesters valid continuously: grants alternate 0,1,0,1.
    mant_a[0] = 53'h111; mant_a[1] = 53'h222;
    req_valid = 2'b11; rsp_ready = 2'b11;
    run_op(0, 57'h1000);
    run_op(1, 57'h1001);
    run_op(0, 57'h1002);
    run_op(1, 57'h1003);

    // req0 div, done 10 cycles after start (rr_q back at 0).
    req_valid = 2'b01; rsp_ready = '0;
    mant_a[0] = 53'h1_2345_6789_ABCD; exp_a[0] = 12'h3FF;
    #1;
    chk("lat_grant", 64'(req_ready), 64'd1);
    tick();                                   // t+1
    req_valid = '0;
    #1;
    chk("lat_div_start", 64'(div_start), 64'd1);
    chk("lat_sqrt_start", 64'(sqrt_start), 64'd0);
    chk("lat_start", 64'(unit_start), 64'd1);
    chk("lat_opa", 64'(u_mant_a), 64'h1_2345_6789_ABCD);
    chk("lat_expa", 64'(u_exp_a), 64'h3FF);
    tick();                                   // t+2
    #1;
    chk("lat_start_once", 64'(div_start), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    repeat (9) tick();                        // t+11
    unit_done = 1'b1; unit_mant_z = 57'h0AB_CDEF_0123_4567; unit_exp_z = 13'h0ABC;
    #1;
    chk("lat_no_early_rsp", 64'(rsp_valid), 64'd0);
    tick();                                   // t+12
    unit_done = 1'b0; rsp_ready = 2'b01;
    #1;
    chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("lat_rsp_mant", 64'(rsp_mant_z), 64'h0AB_CDEF_0123_4567);
    chk("lat_rsp_exp", 64'(rsp_exp_z), 64'h0ABC);
    tick();
    rsp_ready = '0;
    #1;
    chk("lat_rsp_done", 64'(rsp_valid), 64'd0);
    chk("lat_idle", 64'(busy), 64'd0);

    // Sqrt on req1 with response held off for 5 cycles.
    req_valid = 2'b10; req_sqrt = 2'b10; mant_a[1] = 53'h0F0F;
    #1;
    chk("sq_grant", 64'(req_ready), 64'd2);
    tick();
    req_valid = '0;
    #1;
    chk("sq_sqrt_start", 64'(sqrt_start), 64'd1);
    chk("sq_div_start", 64'(div_start), 64'd0);
    tick();
    unit_done = 1'b1; unit_mant_z = 57'h155_5555; z_held = 57'h155_5555;
    tick();
    unit_done = 1'b0; unit_mant_z = 57'h0EE_EEEE; req_valid = 2'b01; req_sqrt = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sq_hold_valid", 64'(rsp_valid), 64'd2);
      chk("sq_hold_z", 64'(rsp_mant_z), 64'(z_held));
      chk("sq_no_grant", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    chk("sq_hs_valid", 64'(rsp_valid), 64'd2);
    tick();
    rsp_ready = '0;

    // req0 granted (rr_q=0), then killed in BUSY with a coincident done.
    #1;
    chk("kb_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    tick();
    kill = 2'b01; unit_done = 1'b1; unit_mant_z = 57'h1234;
    #1;
    chk("kb_kill_pulse", 64'(unit_kill), 64'd1);
    chk("kb_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    kill = '0; unit_done = 1'b0;
    #1;
    chk("kb_idle", 64'(busy), 64'd0);
    chk("kb_kill_once", 64'(unit_kill), 64'd0);
    chk("kb_no_rsp_after", 64'(rsp_valid), 64'd0);

    // rr_q must now be 1: with both valid, req1 wins.
    req_valid = 2'b11;
    #1;
    chk("kb_rr_next", 64'(req_ready), 64'd2);
    tick();
    req_valid = '0; kill = 2'b10;
    #1;
    chk("ki_start_suppressed", 64'(unit_start), 64'd0);
    chk("ki_kill_pulse", 64'(unit_kill), 64'd1);
    tick();
    kill = '0;
    #1;
    chk("ki_idle", 64'(busy), 64'd0);

    // Unit not ready: no grant until it becomes ready.
    unit_ready = 1'b0; req_valid = 2'b01; mant_a[0] = 53'h0777;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ur_no_grant", 64'(req_ready), 64'd0);
      chk("ur_idle", 64'(busy), 64'd0);
      tick();
    end
    unit_ready = 1'b1;
    #1;
    chk("ur_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    tick();
    kill = 2'b10;                             // non-owner kill is ignored
    #1;
    chk("nk_no_kill", 64'(unit_kill), 64'd0);
    chk("nk_busy", 64'(busy), 64'd1);
    tick();
    kill = '0;

    // Asynchronous reset during BUSY, then a stray done.
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_opa", 64'(u_mant_a), 64'd0);
    chk("ar_rsp_z", 64'(rsp_mant_z), 64'd0);
    chk("ar_kill", 64'(unit_kill), 64'd0);
    chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    unit_done = 1'b1; unit_mant_z = 57'h0999;
    tick();
    unit_done = 1'b0;
    #1;
    chk("ar_done_ignored_valid", 64'(rsp_valid), 64'd0);
    chk("ar_done_ignored_busy", 64'(busy), 64'd0);
    chk("ar_done_ignored_z", 64'(rsp_mant_z), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
